// File: rtl/cache_pkg.sv
// Shared types and helpers for the data-cache miss path.
// Line geometry defaults and the block-alignment mask live here.
package cache_pkg;

   localparam int unsigned WORDS_PER_BLOCK = 8;
   localparam int unsigned BLOCK_BYTES     = WORDS_PER_BLOCK * 8;
   localparam int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK);

   typedef enum logic [1:0] {
      StIdle,
      StWb,
      StRefill,
      StDone
   } refill_state_e;

   // Clears the in-line offset bits; block_bytes must be a power of two.
   function automatic logic [63:0] block_base(input logic [63:0] addr,
                                              input int unsigned block_bytes);
      logic [63:0] mask;
      mask = ~(64'(block_bytes) - 64'd1);
      return addr & mask;
   endfunction

endpackage

// File: rtl/beat_counter.sv
// Modulo-N beat counter with synchronous clear, count enable and a last-beat flag.
module beat_counter #(
   parameter int unsigned N = 8,
   localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         last
);

   logic [W-1:0] cnt_q, cnt_d;

   assign cnt  = cnt_q;
   assign last = (cnt_q == W'(N - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = last ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dcache_refill_controller.sv
// Data-cache miss sequencer: optional dirty-line writeback, then line refill, one
// doubleword per beat. Sole owner of the memory request port; keeps miss/wb counters.
module dcache_refill_controller #(
   parameter int unsigned WORDS_PER_BLOCK = 8,
   parameter int unsigned ADDR_W          = 64,
   parameter int unsigned DATA_W          = 64,
   parameter int unsigned CNT_W           = 32,
   localparam int unsigned IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              miss,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic              victim_dirty,
   input  logic [ADDR_W-1:0] victim_addr,
   input  logic [DATA_W-1:0] victim_word,
   output logic [IDX_W-1:0]  word_idx,
   output logic              fill_we,
   output logic [DATA_W-1:0] fill_data,
   output logic              fill_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic [CNT_W-1:0]  miss_count,
   output logic [CNT_W-1:0]  wb_count
);

   import cache_pkg::*;

   localparam int unsigned LINE_BYTES = WORDS_PER_BLOCK * 8;

   refill_state_e     state_q, state_d;
   logic [ADDR_W-1:0] miss_base_q, victim_base_q;
   logic [CNT_W-1:0]  miss_count_q, wb_count_q;
   logic [IDX_W-1:0]  cnt;
   logic              cnt_last;
   logic              take_miss;
   logic              beat_ack;
   logic              wb_end;
   logic [ADDR_W-1:0] beat_off;

   assign take_miss = (state_q == StIdle) && miss;
   // mem_ready only counts while a beat is actually requested
   assign beat_ack  = ((state_q == StWb) || (state_q == StRefill)) && mem_ready;
   assign wb_end    = (state_q == StWb) && mem_ready && cnt_last;
   assign beat_off  = ADDR_W'({cnt, 3'b000});

   beat_counter #(
      .N (WORDS_PER_BLOCK)
   ) u_beat_counter (
      .clk   (clk),
      .reset (reset),
      .clear (take_miss),
      .en    (beat_ack),
      .cnt   (cnt),
      .last  (cnt_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         miss_base_q   <= '0;
         victim_base_q <= '0;
         miss_count_q  <= '0;
         wb_count_q    <= '0;
      end else begin
         state_q <= state_d;
         if (take_miss) begin
            miss_base_q   <= ADDR_W'(block_base(64'(miss_addr), LINE_BYTES));
            victim_base_q <= ADDR_W'(block_base(64'(victim_addr), LINE_BYTES));
            if (miss_count_q != '1) begin
               miss_count_q <= miss_count_q + CNT_W'(1);
            end
         end
         if (wb_end && (wb_count_q != '1)) begin
            wb_count_q <= wb_count_q + CNT_W'(1);
         end
      end
   end

   assign miss_count = miss_count_q;
   assign wb_count   = wb_count_q;

   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      word_idx  = '0;
      fill_we   = 1'b0;
      fill_data = '0;
      fill_done = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Freeze the pipeline in the very cycle the miss is seen.
            stall = miss;
            if (miss) begin
               state_d = victim_dirty ? StWb : StRefill;
            end
         end
         StWb: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = victim_base_q + beat_off;
            word_idx  = cnt;
            mem_wdata = victim_word;
            if (mem_ready && cnt_last) begin
               state_d = StRefill;
            end
         end
         StRefill: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = miss_base_q + beat_off;
            word_idx  = cnt;
            fill_we   = mem_ready;
            fill_data = mem_rdata;
            if (mem_ready && cnt_last) begin
               state_d = StDone;
            end
         end
         StDone: begin
            stall     = 1'b1;
            fill_done = 1'b1;
            state_d   = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Reset must silence the combinational paths too (stall would otherwise follow miss).
      if (reset) begin
         stall     = 1'b0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         word_idx  = '0;
         fill_we   = 1'b0;
         fill_data = '0;
         fill_done = 1'b0;
      end
   end

endmodule

// File: tb/tb_dcache_refill_controller.sv
// Scoreboard bench for dcache_refill_controller: expected beats queued per miss, popped per beat.
module tb_dcache_refill_controller;

   localparam int unsigned N      = 8;
   localparam int unsigned LINE_B = N * 8;
   localparam logic [63:0] RKEY   = 64'hF00D_5A5A_1234_8765;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] data;
      logic [2:0]  idx;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        miss;
   logic [63:0] miss_addr;
   logic        victim_dirty;
   logic [63:0] victim_addr;
   logic [63:0] victim_word;
   logic [2:0]  word_idx;
   logic        fill_we;
   logic [63:0] fill_data;
   logic        fill_done;
   logic        mem_req;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_ready;
   logic [63:0] mem_rdata;
   logic        stall;
   logic [31:0] miss_count;
   logic [31:0] wb_count;

   logic [2:0]  s_word_idx;
   logic        s_fill_we;
   logic [63:0] s_fill_data;
   logic        s_fill_done;
   logic        s_mem_req;
   logic        s_mem_we;
   logic [63:0] s_mem_addr;
   logic [63:0] s_mem_wdata;
   logic        s_stall;
   logic [3:0]  s_miss_count;
   logic [3:0]  s_wb_count;

   beat_t sb[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    exp_miss = 0;
   int    exp_wb   = 0;

   always #5 clk = ~clk;

   assign victim_word = {56'hC0DE_0000_0000_00, 5'd0, word_idx};
   assign mem_rdata   = mem_addr ^ RKEY;

   dcache_refill_controller #(
      .WORDS_PER_BLOCK (N),
      .ADDR_W          (64),
      .DATA_W          (64),
      .CNT_W           (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .miss         (miss),
      .miss_addr    (miss_addr),
      .victim_dirty (victim_dirty),
      .victim_addr  (victim_addr),
      .victim_word  (victim_word),
      .word_idx     (word_idx),
      .fill_we      (fill_we),
      .fill_data    (fill_data),
      .fill_done    (fill_done),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .stall        (stall),
      .miss_count   (miss_count),
      .wb_count     (wb_count)
   );

   // Narrow-counter copy in lockstep, for saturation.
   dcache_refill_controller #(
      .WORDS_PER_BLOCK (N),
      .ADDR_W          (64),
      .DATA_W          (64),
      .CNT_W           (4)
   ) dut_sat (
      .clk          (clk),
      .reset        (reset),
      .miss         (miss),
      .miss_addr    (miss_addr),
      .victim_dirty (victim_dirty),
      .victim_addr  (victim_addr),
      .victim_word  (victim_word),
      .word_idx     (s_word_idx),
      .fill_we      (s_fill_we),
      .fill_data    (s_fill_data),
      .fill_done    (s_fill_done),
      .mem_req      (s_mem_req),
      .mem_we       (s_mem_we),
      .mem_addr     (s_mem_addr),
      .mem_wdata    (s_mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .stall        (s_stall),
      .miss_count   (s_miss_count),
      .wb_count     (s_wb_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One quiet cycle: controller must be idle with nothing requested.
   task automatic idle_check();
      miss      = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      check("idle_stall", 64'(stall), 64'd0);
      check("idle_req", 64'(mem_req), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Drives one miss starting in an IDLE cycle; mem_ready on cycles where cyc % period == 0.
   // abort_cyc >= 0 asserts reset at that cycle's midpoint and returns.
   task automatic run_miss(input logic [63:0] maddr, input logic dirty,
                           input logic [63:0] vaddr, input int period, input int abort_cyc);
      logic [63:0] mbase, vbase, w_addr, w_data;
      logic        waiting, w_we;
      int          cyc, stall_cyc, done_cyc, first_beat, exp_stall;
      beat_t       b, e;
      mbase = maddr & ~64'(LINE_B - 1);
      vbase = vaddr & ~64'(LINE_B - 1);
      if (dirty) begin
         for (int i = 0; i < N; i++) begin
            b.we   = 1'b1;
            b.addr = vbase + 64'(8 * i);
            b.data = {56'hC0DE_0000_0000_00, 5'd0, 3'(i)};
            b.idx  = 3'(i);
            sb.push_back(b);
         end
      end
      for (int i = 0; i < N; i++) begin
         b.we   = 1'b0;
         b.addr = mbase + 64'(8 * i);
         b.data = (mbase + 64'(8 * i)) ^ RKEY;
         b.idx  = 3'(i);
         sb.push_back(b);
      end
      exp_stall = 2 + (dirty ? 2 * N : N) * period;
      miss = 1'b1;
      miss_addr = maddr;
      victim_dirty = dirty;
      victim_addr = vaddr;
      cyc = 0;
      stall_cyc = 0;
      done_cyc = -1;
      first_beat = -1;
      waiting = 1'b0;
      w_addr = '0;
      w_data = '0;
      w_we = 1'b0;
      while ((cyc < exp_stall + 20) && (done_cyc < 0)) begin
         mem_ready = ((cyc % period) == 0);
         @(negedge clk);
         if (cyc == abort_cyc) begin
            reset = 1'b1;
            #1;
            check("rst_stall", 64'(stall), 64'd0);
            check("rst_req", 64'(mem_req), 64'd0);
            check("rst_fill_we", 64'(fill_we), 64'd0);
            check("rst_addr", mem_addr, 64'd0);
            check("rst_idx", 64'(word_idx), 64'd0);
            sb.delete();
            @(posedge clk);
            #1;
            reset = 1'b0;
            miss  = 1'b0;
            return;
         end
         if (stall) stall_cyc++;
         if (waiting && mem_req) begin
            check("hold_addr", mem_addr, w_addr);
            check("hold_wdata", mem_wdata, w_data);
            check("hold_we", 64'(mem_we), 64'(w_we));
         end
         if (mem_req && !mem_ready) check("wait_fill_we", 64'(fill_we), 64'd0);
         if (mem_req && mem_ready) begin
            if (first_beat < 0) first_beat = cyc;
            if (sb.size() == 0) begin
               check("extra_beat", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("beat_we", 64'(mem_we), 64'(e.we));
               check("beat_addr", mem_addr, e.addr);
               check("beat_idx", 64'(word_idx), 64'(e.idx));
               if (e.we) begin
                  check("wb_wdata", mem_wdata, e.data);
               end else begin
                  check("fill_we", 64'(fill_we), 64'd1);
                  check("fill_data", fill_data, e.data);
               end
            end
         end
         waiting = mem_req && !mem_ready;
         w_addr  = mem_addr;
         w_data  = mem_wdata;
         w_we    = mem_we;
         if (fill_done) done_cyc = cyc;
         @(posedge clk);
         #1;
         miss = 1'b0;
         cyc++;
      end
      check("done_cycle", 64'(done_cyc), 64'(exp_stall - 1));
      check("stall_cycles", 64'(stall_cyc), 64'(exp_stall));
      check("first_beat", 64'(first_beat), 64'(period));
      check("beats_left", 64'(sb.size()), 64'd0);
      exp_miss++;
      if (dirty) exp_wb++;
   endtask

   initial begin
      reset        = 1'b1;
      miss         = 1'b1;
      miss_addr    = 64'h1000_0038;
      victim_dirty = 1'b1;
      victim_addr  = '0;
      mem_ready    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_stall", 64'(stall), 64'd0);
      check("reset_req", 64'(mem_req), 64'd0);
      check("reset_done", 64'(fill_done), 64'd0);
      check("reset_miss_cnt", 64'(miss_count), 64'd0);
      check("reset_wb_cnt", 64'(wb_count), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      miss  = 1'b0;
      idle_check();

      // Reset mid-refill (cnt=4), then a fresh miss must start at beat 0.
      run_miss(64'h1000_0038, 1'b0, 64'h0, 1, 5);
      check("abort_miss_cnt", 64'(miss_count), 64'd0);
      idle_check();

      run_miss(64'h1000_0038, 1'b0, 64'h0, 1, -1);
      idle_check();
      check("clean_miss_cnt", 64'(miss_count), 64'(exp_miss));

      run_miss(64'h3000_0000, 1'b1, 64'h2000_0040, 1, -1);
      idle_check();
      check("dirty_wb_cnt", 64'(wb_count), 64'(exp_wb));

      run_miss(64'h4000_0010, 1'b0, 64'h0, 3, -1);
      idle_check();
      run_miss(64'h6000_0123, 1'b1, 64'h5000_00F8, 3, -1);
      idle_check();
      check("wait_miss_cnt", 64'(miss_count), 64'(exp_miss));
      check("wait_wb_cnt", 64'(wb_count), 64'(exp_wb));

      run_miss(64'h7000_0000, 1'b0, 64'h0, 1, -1);
      run_miss(64'h7000_0048, 1'b0, 64'h0, 1, -1);
      idle_check();
      check("b2b_miss_cnt", 64'(miss_count), 64'(exp_miss));

      for (int k = 0; k < 11; k++) begin
         run_miss({$urandom, $urandom}, 1'b0, 64'h0, 1, -1);
      end
      idle_check();
      check("total_miss_cnt", 64'(miss_count), 64'd17);
      check("model_miss_cnt", 64'(miss_count), 64'(exp_miss));
      check("sat_miss_cnt", 64'(s_miss_count), 64'd15);
      check("sat_wb_cnt", 64'(s_wb_count), 64'(exp_wb));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
